// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first shift out on spi_mosi, shift in on spi_miso, one chip select.
// All SPI pins and status outputs come straight from flops.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  spi_cs_n
);

  localparam int CntMaxA = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CntMax  = (CntMaxA > CS_HOLD) ? CntMaxA : CS_HOLD;
  localparam int CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int BitW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StDone} state_e;

  state_e                r_state;
  logic [CntW-1:0]       r_cnt;
  logic [BitW-1:0]       r_bit;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sck;
  logic                  r_mosi;
  logic                  r_cs_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_tx    <= tx_data;
            r_mosi  <= tx_data[DATA_WIDTH-1];
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_bit   <= BitW'(DATA_WIDTH - 1);
            r_cnt   <= CntW'(CS_SETUP - 1);
            r_state <= StSetup;
          end
        end
        StSetup: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cnt   <= CntW'(CLK_DIV - 1);
            r_state <= StXfer;
          end
        end
        StXfer: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_sck) begin
            r_cnt <= CntW'(CLK_DIV - 1);
            r_sck <= 1'b1;
            r_rx  <= {r_rx[DATA_WIDTH-2:0], spi_miso};
          end else begin
            r_sck <= 1'b0;
            if (r_bit != '0) begin
              // Next bit goes out on the falling edge so it is stable across the next rise.
              r_cnt  <= CntW'(CLK_DIV - 1);
              r_bit  <= r_bit - 1'b1;
              r_mosi <= r_tx[DATA_WIDTH-2];
              r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            end else begin
              r_cnt   <= CntW'(CS_HOLD - 1);
              r_state <= StHold;
            end
          end
        end
        StHold: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cs_n    <= 1'b1;
            r_rx_data <= r_rx;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= StDone;
          end
        end
        StDone: begin
          // start is ignored here, giving cs_n at least two high cycles between frames.
          r_done  <= 1'b0;
          r_mosi  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign spi_clk  = r_sck;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a behavioural SPI slave supplies miso and records mosi,
// a monitor checks timing and compares each completed frame against queued expectations.
module tb_spi_master;
  localparam int W        = 8;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int LATENCY  = CS_SETUP + 2 * CLK_DIV * W + CS_HOLD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         busy, done, spi_clk, spi_mosi, spi_cs_n;
  logic [W-1:0] rx_data;
  logic         spi_miso = 1'b0;

  spi_master #(
    .DATA_WIDTH(W),
    .CLK_DIV   (CLK_DIV),
    .CS_SETUP  (CS_SETUP),
    .CS_HOLD   (CS_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural slave: presents its word MSB first, captures mosi on every SCK rise.
  logic [W-1:0] next_sw = '0;
  logic [W-1:0] s_word = '0;
  logic [W-1:0] s_rx = '0;

  always @(negedge spi_cs_n) begin
    s_word   = next_sw;
    s_rx     = '0;
    spi_miso = s_word[W-1];
  end
  always @(posedge spi_clk) if (!spi_cs_n) s_rx = {s_rx[W-2:0], spi_mosi};
  always @(negedge spi_clk) begin
    if (!spi_cs_n) begin
      s_word   = {s_word[W-2:0], 1'b0};
      spi_miso = s_word[W-1];
    end
  end

  typedef struct packed {
    logic [W-1:0] tx;
    logic [W-1:0] sw;
  } exp_t;
  exp_t sb[$];

  // Monitor
  logic        p_busy = 0, p_csn = 1, p_sck = 0, p_mosi = 0, p_done = 0;
  logic        in_frame = 0, check_gap = 0;
  int unsigned acc_cyc = 0, csn_rise_cyc = 0;
  int          nrise = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      nrise    = 0;
    end else begin
      if (busy && !p_busy) begin
        acc_cyc  = cyc;
        nrise    = 0;
        in_frame = 1;
      end
      if (!spi_cs_n && p_csn && check_gap) begin
        chk("cs_n_high_gap", 32'(cyc - csn_rise_cyc), 32'd2);
        check_gap = 0;
      end
      if (spi_cs_n && !p_csn) csn_rise_cyc = cyc;
      if (in_frame && spi_clk && !p_sck) begin
        chk("sck_rise_time", 32'(cyc - acc_cyc), 32'(CS_SETUP + CLK_DIV + 2 * CLK_DIV * nrise));
        nrise++;
      end
      if (spi_clk) chk("mosi_stable_high", 32'(spi_mosi), 32'(p_mosi));
      if (p_done) chk("done_one_cycle", 32'(done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e.sw));
          chk("slave_rx", 32'(s_rx), 32'(e.tx));
          chk("latency", 32'(cyc - acc_cyc), 32'(LATENCY));
          chk("sck_rises", 32'(nrise), 32'(W));
          chk("cs_n_at_done", 32'(spi_cs_n), 32'd1);
          chk("busy_at_done", 32'(busy), 32'd0);
        end
        in_frame = 0;
      end
    end
    p_busy = busy;
    p_csn  = spi_cs_n;
    p_sck  = spi_clk;
    p_mosi = spi_mosi;
    p_done = done;
  end

  task automatic wait_busy(input logic want, input int lim, input string name);
    int n = 0;
    while (busy !== want && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'(want));
  endtask

  task automatic do_frame(input logic [W-1:0] tx, input logic [W-1:0] sw);
    @(negedge clk);
    next_sw = sw;
    tx_data = tx;
    start   = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 20, "accept");
    sb.push_back('{tx: tx, sw: sw});
    start   = 1'b0;
    tx_data = W'($urandom);
    wait_busy(1'b0, 200, "frame_end");
  endtask

  initial begin
    logic [W-1:0] sw2;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sck", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_frame(8'hA5, 8'hA5);
    do_frame(8'hAA, 8'h5A);

    // start issued mid-frame must be ignored
    @(negedge clk);
    next_sw = 8'h3C;
    tx_data = 8'h3C;
    start   = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 20, "accept_3c");
    sb.push_back('{tx: 8'h3C, sw: 8'h3C});
    start = 1'b0;
    repeat (19) @(negedge clk);
    tx_data = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(1'b0, 200, "frame_end_3c");
    repeat (10) @(negedge clk);
    chk("no_second_frame_busy", 32'(busy), 32'd0);
    chk("no_second_frame_cs_n", 32'(spi_cs_n), 32'd1);
    do_frame(8'hFF, 8'hFF);

    // start held high: back-to-back frames
    @(negedge clk);
    next_sw = W'($urandom);
    sw2     = W'($urandom);
    tx_data = 8'h01;
    start   = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 20, "accept_b2b1");
    sb.push_back('{tx: 8'h01, sw: next_sw});
    next_sw = sw2;
    tx_data = 8'h80;
    @(posedge clk);
    #1 check_gap = 1'b1;
    wait_busy(1'b0, 200, "frame_end_b2b1");
    wait_busy(1'b1, 20, "accept_b2b2");
    sb.push_back('{tx: 8'h80, sw: sw2});
    start = 1'b0;
    wait_busy(1'b0, 200, "frame_end_b2b2");

    // reset mid-frame aborts immediately
    @(negedge clk);
    next_sw = 8'h99;
    tx_data = 8'h66;
    start   = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 20, "accept_abort");
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort_sck", 32'(spi_clk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_frame(8'hC3, 8'hC3);

    for (int i = 0; i < 15; i++) do_frame(W'($urandom), W'($urandom));

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
